// File: rtl/dht_reader.sv
// dht_reader: single-wire DHT11/DHT22 reader with start/done handshake,
// checksum verification, encoded error reporting, automatic retry and a
// mandatory hold-off between read attempts.
//
// Handshake: start is a level sampled only while IDLE with en=1; the cycle it
// is seen high the request is accepted (busy rises the next cycle). Requests
// made while busy are dropped, not queued. done is a one-cycle pulse that
// coincides with the final update of valid/error/err_code/raw for that
// request; it is never raised for a request aborted by en=0 or rst.
module dht_reader #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned HOLDOFF_MS  = 1000,
  parameter int unsigned MAX_RETRIES = 2
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic        mode,
  inout  wire         dht_data,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [39:0] raw,
  output logic [15:0] hum,
  output logic [15:0] temp,
  output logic [3:0]  state_dbg
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1_000_000;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [19:0] T_START11 = 20'd18000;
  localparam logic [19:0] T_START22 = 20'd1000;
  localparam logic [19:0] T_RESP    = 20'd100;
  localparam logic [19:0] T_BIT_LOW = 20'd80;
  localparam logic [19:0] T_BIT_HI  = 20'd100;
  localparam logic [19:0] T_ONE     = 20'd40;
  localparam logic [19:0] T_HOLD    = 20'(HOLDOFF_MS * 1000);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_FAIL, S_HOLDOFF
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [19:0]       us_cnt;
  logic [1:0]        settle;
  logic              sync1, sync2;
  logic              mode_q;
  logic [2:0]        retry_cnt;
  logic              retry_flag;
  logic [5:0]        bit_idx;
  logic [39:0]       shift;
  logic [1:0]        fail_code;
  logic [19:0]       limit;
  logic              tick;
  logic              expired;
  logic [7:0]        csum;
  logic              line;

  assign line = sync2;
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign csum = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];

  // The line is only ever pulled low; a released line floats to the pull-up.
  assign dht_data  = (state == S_START_LOW) ? 1'b0 : 1'bz;
  assign busy      = (state != S_IDLE);
  assign hum       = raw[39:24];
  assign temp      = raw[23:8];
  assign state_dbg = state;

  // Per-state time budget in microseconds; expired fires on the tick that reaches it.
  always_comb begin
    limit = T_RESP;
    case (state)
      S_START_LOW: limit = mode_q ? T_START22 : T_START11;
      S_BIT_LOW:   limit = T_BIT_LOW;
      S_BIT_HIGH:  limit = T_BIT_HI;
      S_HOLDOFF:   limit = T_HOLD;
      default:     limit = T_RESP;
    endcase
    expired = tick && (us_cnt >= limit - 20'd1);
  end

  // Main sequencer: synchroniser, microsecond timing and the protocol FSM.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      us_cnt     <= '0;
      settle     <= '0;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      mode_q     <= 1'b0;
      retry_cnt  <= '0;
      retry_flag <= 1'b0;
      bit_idx    <= '0;
      shift      <= '0;
      fail_code  <= 2'b00;
      done       <= 1'b0;
      valid      <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'b00;
      raw        <= '0;
    end else begin
      sync1 <= dht_data;
      sync2 <= sync1;
      done  <= 1'b0;

      if (state != S_IDLE) begin
        if (tick) begin
          tick_cnt <= '0;
          us_cnt   <= us_cnt + 20'd1;
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
        if (settle != 2'd3) settle <= settle + 2'd1;
      end

      if (!en) begin
        state      <= S_IDLE;
        tick_cnt   <= '0;
        us_cnt     <= '0;
        settle     <= '0;
        retry_cnt  <= '0;
        retry_flag <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              mode_q     <= mode;
              valid      <= 1'b0;
              error      <= 1'b0;
              err_code   <= 2'b00;
              retry_cnt  <= '0;
              retry_flag <= 1'b0;
              state <= S_START_LOW; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end
          end
          S_START_LOW: begin
            if (expired) begin
              state <= S_RELEASE; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end
          end
          S_RELEASE: begin
            // Our own low drive is still in the synchroniser for a few cycles.
            if (settle == 2'd3 && !line) begin
              state <= S_RESP_LOW; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end else if (expired) begin
              fail_code <= 2'b01;
              state <= S_FAIL; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end
          end
          S_RESP_LOW: begin
            if (line) begin
              state <= S_RESP_HIGH; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end else if (expired) begin
              fail_code <= 2'b10;
              state <= S_FAIL; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end
          end
          S_RESP_HIGH: begin
            if (!line) begin
              bit_idx <= '0;
              state <= S_BIT_LOW; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end else if (expired) begin
              fail_code <= 2'b10;
              state <= S_FAIL; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end
          end
          S_BIT_LOW: begin
            if (line) begin
              state <= S_BIT_HIGH; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end else if (expired) begin
              fail_code <= 2'b10;
              state <= S_FAIL; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end
          end
          S_BIT_HIGH: begin
            if (!line) begin
              shift <= {shift[38:0], (us_cnt > T_ONE)};
              if (bit_idx == 6'd39) begin
                state <= S_CHECK; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
              end else begin
                bit_idx <= bit_idx + 6'd1;
                state <= S_BIT_LOW; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
              end
            end else if (expired) begin
              fail_code <= 2'b10;
              state <= S_FAIL; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end
          end
          S_CHECK: begin
            if (csum == shift[7:0]) begin
              raw        <= shift;
              valid      <= 1'b1;
              done       <= 1'b1;
              retry_flag <= 1'b0;
              state <= S_HOLDOFF; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end else begin
              fail_code <= 2'b11;
              state <= S_FAIL; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end
          end
          S_FAIL: begin
            // Intermediate failures stay silent; only the last one is reported.
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt  <= retry_cnt + 3'd1;
              retry_flag <= 1'b1;
            end else begin
              error      <= 1'b1;
              err_code   <= fail_code;
              done       <= 1'b1;
              retry_flag <= 1'b0;
            end
            state <= S_HOLDOFF; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
          end
          S_HOLDOFF: begin
            if (expired) begin
              retry_flag <= 1'b0;
              state <= retry_flag ? S_START_LOW : S_IDLE;
              us_cnt <= '0; tick_cnt <= '0; settle <= '0;
            end
          end
          default: begin
            state <= S_IDLE; us_cnt <= '0; tick_cnt <= '0; settle <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht_reader.sv
// tb_dht_reader: drives dht_reader against a behavioural DHT sensor and a
// request-level model of the result registers.
module tb_dht_reader;

  localparam int CLK_HZ      = 1_000_000;
  localparam int HOLDOFF_MS  = 2;
  localparam int MAX_RETRIES = 2;
  localparam int HOLD_CYC    = HOLDOFF_MS * 1000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, en, start, mode;
  logic sens_drv = 1'b0;
  wire  dht_line;
  logic busy, done, valid, error;
  logic [1:0]  err_code;
  logic [39:0] raw;
  logic [15:0] hum, temp;
  logic [3:0]  state_dbg;

  pullup (dht_line);
  assign dht_line = sens_drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dht_reader #(.CLK_HZ(CLK_HZ), .HOLDOFF_MS(HOLDOFF_MS), .MAX_RETRIES(MAX_RETRIES)) dut (
    .clk_100MHz(clk), .rst(rst), .en(en), .start(start), .mode(mode),
    .dht_data(dht_line), .busy(busy), .done(done), .valid(valid), .error(error),
    .err_code(err_code), .raw(raw), .hum(hum), .temp(temp), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fails  = 0;
  bit finished = 1'b0;

  task automatic finish_up();
    if (!finished) begin
      finished = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      if (n_fails >= 50) finish_up();
    end
  endtask

  // Request-level model: current result registers and the predicted outcome
  // of the request in flight.
  logic        m_valid = 1'b0, m_error = 1'b0;
  logic [1:0]  m_code  = 2'b00;
  logic [39:0] m_raw   = '0;
  logic        pend    = 1'b0;
  logic        p_valid, p_error;
  logic [1:0]  p_code;
  logic [39:0] p_raw;
  logic        chk_on  = 1'b0;
  logic        prev_done = 1'b0;
  int          done_cnt = 0;
  int          done_cyc = 0;

  // Compare process: every cycle, outputs versus the model.
  always begin
    @(posedge clk);
    #2;
    if (chk_on) begin
      if (done) begin
        check("done_expected", pend, 1'b1);
        done_cnt++;
        done_cyc = cyc;
        if (pend) begin
          m_valid = p_valid; m_error = p_error; m_code = p_code; m_raw = p_raw;
          pend = 1'b0;
        end
      end
      check("done_one_cycle", done && prev_done, 1'b0);
      prev_done = done;
      check("valid", valid, m_valid);
      check("error", error, m_error);
      check("err_code", err_code, m_code);
      check("raw", raw, m_raw);
      check("hum", hum, m_raw[39:24]);
      check("temp", temp, m_raw[23:8]);
      check("valid_and_error", valid && error, 1'b0);
    end
  end

  // ---------------- behavioural sensor ----------------
  logic [39:0] s_frame   = '0;
  logic        s_present = 1'b0;
  int          s_stretch = -1;
  int          s_bit     = -1;
  logic        s_high    = 1'b0;
  int          p_len_q[$];
  int          p_start_q[$];

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic respond();
    wait_cyc(30);
    sens_drv = 1'b1; wait_cyc(80);
    sens_drv = 1'b0; wait_cyc(80);
    for (int i = 0; i < 40; i++) begin
      s_bit = i; s_high = 1'b0;
      sens_drv = 1'b1; wait_cyc(50);
      sens_drv = 1'b0; s_high = 1'b1;
      if (i == s_stretch) begin
        wait_cyc(150);
        s_high = 1'b0; s_bit = -1;
        return;
      end
      wait_cyc(s_frame[39 - i] ? 70 : 26);
    end
    s_high = 1'b0;
    sens_drv = 1'b1; wait_cyc(50);
    sens_drv = 1'b0;
    s_bit = -1;
  endtask

  // Sensor: log every host low pulse, then answer it if present.
  initial begin : sensor
    int st;
    forever begin
      @(posedge clk);
      #1;
      if (dht_line === 1'b0 && !sens_drv) begin
        st = cyc;
        while (dht_line !== 1'b1) begin
          @(posedge clk);
          #1;
        end
        p_start_q.push_back(st);
        p_len_q.push_back(cyc - st);
        if (s_present) respond();
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [39:0] good_frame();
    logic [7:0] b0, b1, b2, b3, b4;
    b0 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255)); b3 = 8'($urandom_range(0, 255));
    b4 = b0 + b1 + b2 + b3;
    return {b0, b1, b2, b3, b4};
  endfunction

  task automatic issue_start(input logic md);
    @(negedge clk);
    mode = md; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_valid = 1'b0; m_error = 1'b0; m_code = 2'b00;
    #1;
    check("busy_after_start", busy, 1'b1);
    check("line_low_after_start", dht_line, 1'b0);
  endtask

  task automatic run_read(input logic md, input logic [39:0] frame, input logic present,
                          input int stretch, input logic poke_holdoff);
    logic       good;
    logic [1:0] code;
    int attempts, np0, dc0, w, fall_cyc, gap;
    logic [7:0] sum;
    s_frame = frame; s_present = present; s_stretch = stretch;
    sum  = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    good = present && (stretch < 0) && (sum == frame[7:0]);
    code = !present ? 2'b01 : (stretch >= 0) ? 2'b10 : good ? 2'b00 : 2'b11;
    attempts = good ? 1 : MAX_RETRIES + 1;
    p_valid = good; p_error = !good; p_code = code; p_raw = good ? frame : m_raw;
    np0 = p_len_q.size(); dc0 = done_cnt;
    issue_start(md);
    pend = 1'b1;
    w = 0;
    while (done_cnt == dc0 && w < 80000) begin
      @(posedge clk); #3; w++;
    end
    check("done_within_budget", done_cnt != dc0, 1'b1);
    if (done_cnt == dc0) pend = 1'b0;
    if (poke_holdoff) begin
      repeat ($urandom_range(10, 1500)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    w = 0;
    while (busy && w < 10000) begin
      @(posedge clk); #3; w++;
    end
    fall_cyc = cyc;
    check("busy_falls", busy, 1'b0);
    check("holdoff_len", fall_cyc - done_cyc, HOLD_CYC);
    repeat (20) @(posedge clk);
    #3;
    check("no_restart", busy, 1'b0);
    check("one_done_per_request", done_cnt - dc0, 1);
    check("pulse_count", p_len_q.size() - np0, attempts);
    for (int i = np0; i < p_len_q.size(); i++) begin
      check("start_pulse_len", p_len_q[i], md ? 1000 : 18000);
      if (!present && i > np0) begin
        gap = p_start_q[i] - (p_start_q[i-1] + p_len_q[i-1]);
        check("retry_gap", (gap >= HOLD_CYC + 100) && (gap <= HOLD_CYC + 104), 1'b1);
      end
    end
  endtask

  task automatic abort_mid(input logic use_rst);
    int dc0, w;
    s_frame = good_frame(); s_present = 1'b1; s_stretch = -1;
    dc0 = done_cnt;
    issue_start(1'b1);
    w = 0;
    while (!(s_bit == 20 && s_high) && w < 10000) begin
      @(posedge clk); #3; w++;
    end
    check("reach_bit20", s_bit == 20 && s_high, 1'b1);
    @(negedge clk);
    if (use_rst) begin
      rst = 1'b1;
      m_valid = 1'b0; m_error = 1'b0; m_code = 2'b00; m_raw = '0;
    end else begin
      en = 1'b0;
    end
    @(posedge clk);
    #3;
    check("abort_idle", busy, 1'b0);
    check("abort_line_released", dht_line, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    while (s_bit != -1 && w < 10000) begin
      @(posedge clk); #3; w++;
    end
    check("sensor_frame_end", s_bit, -1);
    @(negedge clk);
    en = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    check("abort_no_done", done_cnt - dc0, 0);
    check("abort_stays_idle", busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    logic [39:0] f;
    rst = 1'b1; en = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_valid", valid, 1'b0);
    check("reset_error", error, 1'b0);
    check("reset_err_code", err_code, 2'b00);
    check("reset_raw", raw, 40'h0);
    check("reset_line", dht_line, 1'b1);
    rst = 1'b0;
    chk_on = 1'b1;

    // DHT11 reference frame.
    run_read(1'b0, 40'h3700190050, 1'b1, -1, 1'b0);
    check("t1_hum", hum, 16'h3700);
    check("t1_temp", temp, 16'h1900);
    check("t1_valid", valid, 1'b1);
    check("t1_err_code", err_code, 2'b00);

    // DHT22 reference frame.
    run_read(1'b1, 40'h028C015FEE, 1'b1, -1, 1'b0);
    check("t2_raw", raw, 40'h028C015FEE);

    // No sensor: three attempts, one final error.
    run_read(1'b1, 40'h0, 1'b0, -1, 1'b0);
    check("t3_err_code", err_code, 2'b01);
    check("t3_error", error, 1'b1);
    check("t3_raw_kept", raw, 40'h028C015FEE);

    // Random data with a corrupted checksum.
    f = good_frame();
    f[7:0] = f[7:0] + 8'($urandom_range(1, 255));
    run_read(1'b1, f, 1'b1, -1, 1'b0);
    check("t4_err_code", err_code, 2'b11);
    check("t4_valid", valid, 1'b0);
    check("t4_raw_kept", raw, 40'h028C015FEE);

    // Stretched data bit, plus a start pulse dropped during hold-off.
    run_read(1'b1, good_frame(), 1'b1, $urandom_range(0, 15), 1'b1);
    check("t5_err_code", err_code, 2'b10);

    // Abort by en=0 keeps results; abort by rst clears them.
    abort_mid(1'b0);
    check("en_abort_raw_kept", raw, 40'h028C015FEE);
    check("en_abort_code_kept", err_code, 2'b00);
    abort_mid(1'b1);
    check("rst_abort_raw", raw, 40'h0);
    check("rst_abort_valid", valid, 1'b0);

    finish_up();
  end

endmodule
